// File: rtl/iob_eth_mii_frame_gen_pkg.sv
// Shared definitions for the MII frame generator and its CRC-32 helper:
// FSM encoding, on-wire framing bytes and CRC-32 constants.
package iob_eth_mii_frame_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_ABORT,
        ST_IFG
    } state_e;

    localparam logic [7:0]  PREAMBLE = 8'h55;
    localparam logic [7:0]  SFD      = 8'hD5;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

    localparam int CNT_W = 11;
    localparam int TMR_W = 16;

endpackage

// File: rtl/iob_eth_crc32_byte.sv
// Combinational IEEE 802.3 CRC-32 update by one byte (reflected, LSB first).
// Shared with the receive-side FCS checker.
module iob_eth_crc32_byte
    import iob_eth_mii_frame_gen_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    always_comb begin
        logic [31:0] c;
        c = crc_i ^ {24'h0, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/iob_eth_mii_frame_gen.sv
// PHY-side MII frame source: wraps a byte stream with preamble/SFD, optional
// zero padding and FCS, and drives MRxD/MRxDv/MRxEr with the inter-frame gap.
module iob_eth_mii_frame_gen
    import iob_eth_mii_frame_gen_pkg::*;
#(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_BYTES      = 12,
    parameter int MIN_LEN        = 60,
    parameter bit PAD_EN         = 1'b1
) (
    input  logic       clk_i,
    input  logic       cke_i,
    input  logic       rst_i,
    input  logic       s_valid_i,
    input  logic [7:0] s_data_i,
    input  logic       s_last_i,
    output logic       s_ready_o,
    input  logic       fcs_en_i,
    output logic [3:0] mii_d_o,
    output logic       mii_dv_o,
    output logic       mii_er_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam logic [TMR_W-1:0] PRE_LAST = TMR_W'(PREAMBLE_BYTES * 2 - 1);
    localparam logic [TMR_W-1:0] IFG_LAST = TMR_W'(IFG_BYTES * 2 - 1);
    localparam logic [TMR_W-1:0] FCS_LAST = TMR_W'(7);
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [31:0]       crc_q, crc_d, crc_upd;
    logic [7:0]        byte_q, byte_d, crc_data;
    logic              last_q, last_d;
    logic              fcs_en_q, fcs_en_d;
    logic [3:0]        nib_q, nib_d;
    logic              ready_q, ready_d;
    logic              dv_q, dv_d;
    logic              er_q, er_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept_slot, payload_end, start;

    // Cycles where s_ready_o is high: a payload byte is taken or the frame underruns.
    assign accept_slot = ((state_q == ST_SFD) && tmr_q[0]) ||
                         ((state_q == ST_DATA) && tmr_q[0] && !last_q);
    assign payload_end = ((state_q == ST_DATA) && tmr_q[0] && last_q) ||
                         ((state_q == ST_PAD) && tmr_q[0]);
    // The last IFG cycle may launch the next frame so the gap stays exact.
    assign start       = s_valid_i &&
                         ((state_q == ST_IDLE) || ((state_q == ST_IFG) && (tmr_q == IFG_LAST)));
    assign crc_data    = accept_slot ? s_data_i : 8'h00;
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    iob_eth_crc32_byte u_crc (
        .crc_i  (crc_q),
        .data_i (crc_data),
        .crc_o  (crc_upd)
    );

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q + 1'b1;
        cnt_d    = cnt_q;
        crc_d    = crc_q;
        byte_d   = byte_q;
        last_d   = last_q;
        fcs_en_d = fcs_en_q;
        nib_d    = 4'h0;
        ready_d  = 1'b0;
        dv_d     = 1'b1;
        er_d     = 1'b0;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                dv_d   = 1'b0;
                busy_d = 1'b0;
                tmr_d  = '0;
            end
            ST_PRE: begin
                nib_d = PREAMBLE[3:0];
                if (tmr_q == PRE_LAST) begin
                    state_d = ST_SFD;
                    tmr_d   = '0;
                    nib_d   = SFD[3:0];
                end
            end
            ST_SFD: begin
                if (!tmr_q[0]) begin
                    nib_d   = SFD[7:4];
                    ready_d = 1'b1;
                end
            end
            ST_DATA: begin
                if (!tmr_q[0]) begin
                    nib_d   = byte_q[7:4];
                    ready_d = !last_q;
                end
            end
            ST_PAD: begin
                nib_d = 4'h0;
            end
            ST_FCS: begin
                nib_d = crc_q[3:0];
                crc_d = crc_q >> 4;
                if (tmr_q == FCS_LAST) begin
                    state_d = ST_IFG;
                    tmr_d   = '0;
                    dv_d    = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_ABORT: begin
                er_d = 1'b1;
                if (tmr_q[0]) begin
                    state_d = ST_IFG;
                    tmr_d   = '0;
                    dv_d    = 1'b0;
                    er_d    = 1'b0;
                    err_d   = 1'b1;
                end
            end
            ST_IFG: begin
                dv_d = 1'b0;
                if (tmr_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dv_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (accept_slot) begin
            tmr_d = '0;
            if (s_valid_i) begin
                state_d = ST_DATA;
                byte_d  = s_data_i;
                last_d  = s_last_i;
                crc_d   = crc_upd;
                cnt_d   = cnt_inc;
                nib_d   = s_data_i[3:0];
            end else begin
                state_d = ST_ABORT;
                er_d    = 1'b1;
                nib_d   = 4'h0;
            end
        end

        if (payload_end) begin
            tmr_d = '0;
            if (PAD_EN && (cnt_q < MIN_CNT)) begin
                state_d = ST_PAD;
                crc_d   = crc_upd;
                cnt_d   = cnt_inc;
            end else if (fcs_en_q) begin
                // FCS leaves as ~CRC, least significant nibble first.
                state_d = ST_FCS;
                nib_d   = ~crc_q[3:0];
                crc_d   = ~crc_q >> 4;
            end else begin
                state_d = ST_IFG;
                dv_d    = 1'b0;
                done_d  = 1'b1;
            end
        end

        if (start) begin
            state_d  = ST_PRE;
            tmr_d    = '0;
            cnt_d    = '0;
            crc_d    = CRC_INIT;
            last_d   = 1'b0;
            fcs_en_d = fcs_en_i;
            nib_d    = PREAMBLE[3:0];
            dv_d     = 1'b1;
            busy_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            fcs_en_q <= 1'b0;
            nib_q    <= 4'h0;
            ready_q  <= 1'b0;
            dv_q     <= 1'b0;
            er_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (cke_i) begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            fcs_en_q <= fcs_en_d;
            nib_q    <= nib_d;
            ready_q  <= ready_d;
            dv_q     <= dv_d;
            er_q     <= er_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Datapath registers are always (re)initialised at frame start.
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            crc_q  <= crc_d;
            byte_q <= byte_d;
        end
    end

    assign s_ready_o = ready_q;
    assign mii_d_o   = nib_q;
    assign mii_dv_o  = dv_q;
    assign mii_er_o  = er_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_iob_eth_mii_frame_gen.sv
// Self-checking bench: table-driven and randomized frames compared against a
// byte-level frame model, plus underrun, back-to-back, reset and clock-enable cases.
`timescale 1ns/1ps
module tb_iob_eth_mii_frame_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, cke = 1'b1, s_valid = 1'b0, s_last = 1'b0, fcs_en = 1'b0, sel = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       v0, v1;
    logic       rdy0, dv0, er0, busy0, done0, err0;
    logic       rdy1, dv1, er1, busy1, done1, err1;
    logic [3:0] d0, d1;
    logic       rdy, dv, er, busy, done, err;
    logic [3:0] d;

    // sel=0 drives the padding instance, sel=1 the non-padding instance.
    assign v0   = s_valid & ~sel;
    assign v1   = s_valid & sel;
    assign rdy  = sel ? rdy1  : rdy0;
    assign dv   = sel ? dv1   : dv0;
    assign er   = sel ? er1   : er0;
    assign busy = sel ? busy1 : busy0;
    assign done = sel ? done1 : done0;
    assign err  = sel ? err1  : err0;
    assign d    = sel ? d1    : d0;

    iob_eth_mii_frame_gen #(.PAD_EN(1'b1)) dut_pad (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .s_valid_i(v0), .s_data_i(s_data),
        .s_last_i(s_last), .s_ready_o(rdy0), .fcs_en_i(fcs_en), .mii_d_o(d0),
        .mii_dv_o(dv0), .mii_er_o(er0), .busy_o(busy0), .done_o(done0), .err_o(err0)
    );

    iob_eth_mii_frame_gen #(.PAD_EN(1'b0)) dut_nopad (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .s_valid_i(v1), .s_data_i(s_data),
        .s_last_i(s_last), .s_ready_o(rdy1), .fcs_en_i(fcs_en), .mii_d_o(d1),
        .mii_dv_o(dv1), .mii_er_o(er1), .busy_o(busy1), .done_o(done1), .err_o(err1)
    );

    typedef struct packed {
        logic       dv, er, done, err, busy, rdy;
        logic [3:0] d;
    } samp_t;

    typedef struct {
        bit          pad;
        bit          fcs;
        int          len;
        bit          rnd;
        logic [7:0]  base;
        int          exp_dv;
        bit          chk_fcs;
        logic [31:0] fcs_word;
    } vec_t;

    samp_t      cap[$];
    logic [7:0] pl[$];
    bit         pll[$];
    logic [3:0] exp_n[$];
    int         checks = 0;
    int         failures = 0;

    task automatic chk_eq(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic fill(input int len, input bit rnd, input logic [7:0] base);
        pl.delete();
        pll.delete();
        for (int i = 0; i < len; i++) begin
            pl.push_back(rnd ? 8'($urandom) : base + 8'(i));
            pll.push_back(i == len - 1);
        end
    endtask

    // Frame model: preamble, SFD, payload (truncated on underrun), zero pad, FCS.
    task automatic build(input bit pad, input bit fcs, input int n, input int ur);
        logic [7:0]  b[$];
        logic [31:0] crc, fw;
        logic        fb;
        int          m;
        exp_n.delete();
        m = (ur >= 0) ? ur : n;
        for (int i = 0; i < m; i++) b.push_back(pl[i]);
        if (ur < 0) begin
            if (pad) while (b.size() < 60) b.push_back(8'h00);
            crc = 32'hFFFF_FFFF;
            foreach (b[i]) begin
                for (int k = 0; k < 8; k++) begin
                    fb  = crc[0] ^ b[i][k];
                    crc = crc >> 1;
                    if (fb) crc = crc ^ 32'hEDB8_8320;
                end
            end
            fw = ~crc;
            if (fcs) for (int k = 0; k < 4; k++) b.push_back(fw[8*k +: 8]);
        end
        for (int i = 0; i < 15; i++) exp_n.push_back(4'h5);
        exp_n.push_back(4'hD);
        foreach (b[i]) begin
            exp_n.push_back(b[i][3:0]);
            exp_n.push_back(b[i][7:4]);
        end
        if (ur >= 0) begin
            exp_n.push_back(4'h0);
            exp_n.push_back(4'h0);
        end
    endtask

    task automatic run(input int ncyc, input int ur_at, input int rst_at,
                       input int frz_at, input int frz_len);
        int    idx, w;
        bit    hs, ck_prev;
        samp_t s;
        cap.delete();
        idx = 0;
        w = 0;
        while (busy && w < 400) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk_eq("idle_before_start", busy, 0);
        s_valid = (pl.size() > 0);
        s_data  = pl[0];
        s_last  = pll[0];
        for (int c = 0; c < ncyc; c++) begin
            cke = !(frz_len > 0 && c >= frz_at && c < frz_at + frz_len);
            if (c == rst_at) begin
                rst = 1'b1;
                s_valid = 1'b0;
            end
            hs = s_valid && rdy && cke;
            ck_prev = cke;
            @(posedge clk);
            #1;
            if (rst) begin
                rst = 1'b0;
                chk_eq("rst_midframe_outputs", {rdy, d, dv, er, busy, done, err}, 0);
                break;
            end
            if (hs) begin
                idx++;
                if (idx < pl.size() && idx != ur_at) begin
                    s_data = pl[idx];
                    s_last = pll[idx];
                end else begin
                    s_valid = 1'b0;
                end
            end
            s = '{dv: dv, er: er, done: done, err: err, busy: busy, rdy: rdy, d: d};
            if (!ck_prev) chk_eq("cke_hold", {s.d, s.dv, s.er, s.rdy},
                                 {cap[$].d, cap[$].dv, cap[$].er, cap[$].rdy});
            else cap.push_back(s);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        cke     = 1'b1;
    endtask

    task automatic chk_frame(input string nm, input int from, input bit abort, input int exp_len,
                             input bit chk_idle, output int f, output int e);
        int L, bad, ner, nd, ne, fr;
        bit ok;
        f = -1;
        for (int i = from; i < cap.size(); i++) if (cap[i].dv) begin f = i; break; end
        if (f < 0) begin
            chk_eq({nm, "_start"}, 0, 1);
            e = cap.size();
            return;
        end
        if (from == 0) chk_eq({nm, "_latency"}, f, 0);
        fr = -1;
        for (int i = f; i < cap.size(); i++) if (cap[i].rdy) begin fr = i; break; end
        chk_eq({nm, "_first_ready"}, fr, f + 15);
        L = 0;
        while (f + L < cap.size() && cap[f + L].dv) L++;
        e = f + L;
        chk_eq({nm, "_dvlen_model"}, L, exp_n.size());
        if (exp_len >= 0) chk_eq({nm, "_dvlen"}, L, exp_len);
        bad = 0;
        ner = 0;
        for (int i = 0; i < L; i++) begin
            if (i < exp_n.size() && cap[f + i].d !== exp_n[i]) bad++;
            if (cap[f + i].er) ner++;
        end
        chk_eq({nm, "_nibble_errors"}, bad, 0);
        chk_eq({nm, "_er_cycles"}, ner, abort ? 2 : 0);
        nd = 0;
        ne = 0;
        for (int i = f; i < f + L + 24 && i < cap.size(); i++) begin
            if (cap[i].done) nd++;
            if (cap[i].err) ne++;
        end
        chk_eq({nm, "_done_count"}, nd, abort ? 0 : 1);
        chk_eq({nm, "_err_count"}, ne, abort ? 1 : 0);
        if (e < cap.size()) chk_eq({nm, "_end_pulse"}, {cap[e].done, cap[e].err}, abort ? 2'b01 : 2'b10);
        else chk_eq({nm, "_end_pulse"}, 0, 1);
        ok = 1'b1;
        for (int i = e; i < e + 24; i++) if (i >= cap.size() || cap[i].dv || !cap[i].busy) ok = 1'b0;
        chk_eq({nm, "_ifg"}, ok, 1);
        if (chk_idle) begin
            if (e + 24 < cap.size()) chk_eq({nm, "_idle_after_ifg"}, {cap[e + 24].busy, cap[e + 24].dv}, 0);
            else chk_eq({nm, "_idle_after_ifg"}, 0, 1);
        end
    endtask

    vec_t tbl[8];

    initial begin
        int          f, e, f2, e2, len;
        bit          pad, fcs;
        logic [31:0] w;

        tbl[0] = '{1'b1, 1'b1, 1,  1'b0, 8'hAB, 144, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b0, 4,  1'b0, 8'h01, 24,  1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 9,  1'b0, 8'h31, 42,  1'b1, 32'hCBF4_3926};
        tbl[3] = '{1'b1, 1'b1, 64, 1'b1, 8'h00, 152, 1'b0, 32'h0};
        tbl[4] = '{1'b1, 1'b0, 10, 1'b1, 8'h00, 136, 1'b0, 32'h0};
        tbl[5] = '{1'b0, 1'b1, 17, 1'b1, 8'h00, 58,  1'b0, 32'h0};
        tbl[6] = '{1'b1, 1'b1, 60, 1'b1, 8'h00, 144, 1'b0, 32'h0};
        tbl[7] = '{1'b1, 1'b1, 59, 1'b1, 8'h00, 144, 1'b0, 32'h0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("reset_state", {rdy0, d0, dv0, er0, busy0, done0, err0,
                               rdy1, d1, dv1, er1, busy1, done1, err1}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int t = 0; t < 8; t++) begin
            sel    = !tbl[t].pad;
            fcs_en = tbl[t].fcs;
            fill(tbl[t].len, tbl[t].rnd, tbl[t].base);
            build(tbl[t].pad, tbl[t].fcs, tbl[t].len, -1);
            run(exp_n.size() + 40, -1, -1, -1, 0);
            chk_frame($sformatf("vec%0d", t), 0, 1'b0, tbl[t].exp_dv, 1'b1, f, e);
            if (tbl[t].chk_fcs) begin
                w = '0;
                for (int k = 0; k < 8; k++) if (e - 8 + k >= 0) w[4*k +: 4] = cap[e - 8 + k].d;
                chk_eq($sformatf("vec%0d_fcs_value", t), w, tbl[t].fcs_word);
            end
        end

        for (int r = 0; r < 4; r++) begin
            len    = $urandom_range(1, 80);
            pad    = 1'($urandom_range(0, 1));
            fcs    = 1'($urandom_range(0, 1));
            sel    = !pad;
            fcs_en = fcs;
            fill(len, 1'b1, 8'h00);
            build(pad, fcs, len, -1);
            run(exp_n.size() + 40, -1, -1, -1, 0);
            chk_frame($sformatf("rand%0d", r), 0, 1'b0, -1, 1'b1, f, e);
        end

        sel    = 1'b0;
        fcs_en = 1'b1;
        fill(8, 1'b1, 8'h00);
        build(1'b1, 1'b1, 8, 4);
        run(exp_n.size() + 40, 4, -1, -1, 0);
        chk_frame("underrun", 0, 1'b1, 26, 1'b1, f, e);

        fill(64, 1'b1, 8'h00);
        for (int i = 0; i < 64; i++) begin
            pl.push_back(pl[i]);
            pll.push_back(pll[i]);
        end
        build(1'b1, 1'b1, 64, -1);
        run(2 * (exp_n.size() + 24) + 20, -1, -1, -1, 0);
        chk_frame("b2b_first", 0, 1'b0, 152, 1'b0, f, e);
        chk_frame("b2b_second", e, 1'b0, 152, 1'b1, f2, e2);
        chk_eq("b2b_gap", f2 - e, 24);

        fill(30, 1'b1, 8'h00);
        run(60, -1, 25, -1, 0);
        fill(5, 1'b1, 8'h00);
        build(1'b1, 1'b1, 5, -1);
        run(exp_n.size() + 40, -1, -1, -1, 0);
        chk_frame("after_reset", 0, 1'b0, 144, 1'b1, f, e);

        fill(1, 1'b0, 8'h3C);
        build(1'b1, 1'b1, 1, -1);
        run(exp_n.size() + 45, -1, -1, 60, 5);
        chk_frame("cke_freeze", 0, 1'b0, 144, 1'b1, f, e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
